// File: rtl/onehot_step_sequencer_pkg.sv
// Shared definitions for the SAP control-section step sequencer.
//   SEL_W_DEF / N_OUT_DEF : default index width and output count
//   step_t                : step index type for the default 4-bit width
//   T1..T6                : T-state indices as seen on the one-hot strobes
//   SAP_LAST_STEP         : SAP instruction cycle is six T-states (T1..T6)
package onehot_step_sequencer_pkg;

  localparam int SEL_W_DEF = 4;
  localparam int N_OUT_DEF = 1 << SEL_W_DEF;

  typedef logic [SEL_W_DEF-1:0] step_t;

  localparam step_t T1 = step_t'(0);
  localparam step_t T2 = step_t'(1);
  localparam step_t T3 = step_t'(2);
  localparam step_t T4 = step_t'(3);
  localparam step_t T5 = step_t'(4);
  localparam step_t T6 = step_t'(5);

  localparam step_t SAP_LAST_STEP = T6;

endpackage

// File: rtl/onehot_step_sequencer_onehot_encode.sv
// Combinational binary -> one-hot decoder.
//   sel    : binary index, SEL_W bits
//   onehot : N_OUT bits, bit sel set; all-zero when sel >= N_OUT
module onehot_encode #(
  parameter int SEL_W = 4,
  parameter int N_OUT = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_OUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (sel == SEL_W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/onehot_step_sequencer.sv
// Registered one-hot step sequencer (T-state generator).
//   clk, rst   : clock, synchronous active-high reset
//   en         : advance one step
//   load       : jump to load_sel (flags load_err if out of range)
//   load_sel   : load target
//   restart    : return to step 0 early, pulsing wrap
//   step       : current binary step
//   out        : registered one-hot of step
//   wrap       : one-cycle pulse after a wrap-to-0 or restart
//   load_err   : sticky out-of-range load flag, cleared by rst
// Priority: rst > load > restart > en > hold.
module onehot_step_sequencer
  import onehot_step_sequencer_pkg::*;
#(
  parameter int SEL_W     = SEL_W_DEF,
  parameter int N_OUT     = 1 << SEL_W,
  parameter int LAST_STEP = N_OUT - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [SEL_W-1:0] load_sel,
  input  logic             restart,
  output logic [SEL_W-1:0] step,
  output logic [N_OUT-1:0] out,
  output logic             wrap,
  output logic             load_err
);

  // One extra bit so N_OUT == 2^SEL_W is representable.
  localparam logic [SEL_W:0] N_OUT_W = (SEL_W+1)'(N_OUT);
  localparam logic [SEL_W:0] LAST_W  = (SEL_W+1)'(LAST_STEP);
  localparam logic [SEL_W:0] TOP_W   = (SEL_W+1)'(N_OUT - 1);
  localparam logic [N_OUT-1:0] OUT_RST = N_OUT'(1);

  logic [SEL_W-1:0] step_nxt;
  logic [N_OUT-1:0] out_nxt;
  logic             wrap_nxt;
  logic             err_nxt;
  logic             sel_ok;
  logic             at_end;

  assign sel_ok = {1'b0, load_sel} < N_OUT_W;
  // Wrap at LAST_STEP, or at the top output for steps loaded above LAST_STEP.
  assign at_end = ({1'b0, step} == LAST_W) || ({1'b0, step} == TOP_W);

  always_comb begin
    step_nxt = step;
    wrap_nxt = 1'b0;
    err_nxt  = load_err;
    if (load) begin
      if (sel_ok) step_nxt = load_sel;
      else        err_nxt  = 1'b1;
    end else if (restart) begin
      step_nxt = '0;
      wrap_nxt = 1'b1;
    end else if (en) begin
      if (at_end) begin
        step_nxt = '0;
        wrap_nxt = 1'b1;
      end else begin
        step_nxt = step + SEL_W'(1);
      end
    end
  end

  // out is registered from the decoded next step, never decoded from step.
  onehot_encode #(
    .SEL_W (SEL_W),
    .N_OUT (N_OUT)
  ) u_enc (
    .sel    (step_nxt),
    .onehot (out_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      step     <= '0;
      out      <= OUT_RST;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      step     <= step_nxt;
      out      <= out_nxt;
      wrap     <= wrap_nxt;
      load_err <= err_nxt;
    end
  end

endmodule

// File: doc/onehot_step_sequencer.md
# onehot_step_sequencer

Parametrised, registered one-hot step sequencer for the SAP control section. A binary step index counts on every enabled clock, wraps at a programmable last step, and drives a registered one-hot output, so every output is defined from the first clock after reset. Control logic can load a step directly, or restart the sequence early to shorten instructions with fewer T-states. Outputs feed the control matrix as T-state strobes, or any consumer of the decoded one-hot enables.

## Interface
Parameters:
- SEL_W, 4, width of the binary step index.
- N_OUT, 1 << SEL_W, number of one-hot outputs; legal range 2 .. 2^SEL_W.
- LAST_STEP, N_OUT-1, step after which the sequence wraps to 0; legal range 1 .. N_OUT-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance one step this cycle.
- load  in  1  jump to load_sel this cycle.
- load_sel  in  SEL_W  target step for load.
- restart  in  1  early return to step 0, skipping remaining steps.
- step  out  SEL_W  current binary step index.
- out  out  N_OUT  registered one-hot of step; bit step is 1.
- wrap  out  1  registered 1-cycle pulse, high in the cycle after a LAST_STEP -> 0 advance or a restart.
- load_err  out  1  sticky flag: set by load with load_sel >= N_OUT; cleared only by rst.

## Operation
- Reset values: step = 0, out = 1 (bit 0 only), wrap = 0, load_err = 0.
- Priority per edge: rst > load > restart > en > hold.
- load:
  - If load_sel < N_OUT: step <= load_sel.
  - If load_sel >= N_OUT: step unchanged, load_err <= 1.
  - wrap <= 0 in both cases.
- restart (no load): step <= 0, wrap <= 1, regardless of en or the current step. restart at step 0 still pulses wrap.
- en (no load, no restart):
  - step == LAST_STEP: step <= 0, wrap <= 1.
  - Otherwise: step <= step + 1, wrap <= 0.
- Hold (none of the above): step unchanged, wrap <= 0.
- Steps above LAST_STEP are reachable only via load. Advancing from such a step continues incrementing. At N_OUT-1 it wraps to 0 with a wrap pulse.
- out is always exactly one-hot and never X or all-zero after the first reset edge.
- out is a register, updated on the same edge as step, not decoded combinationally from step.
- Width rules:
  - Step increment is SEL_W bits wide.
  - Comparisons against LAST_STEP and N_OUT are unsigned.
  - The N_OUT == 2^SEL_W case must not overflow the comparison constant; widen it to SEL_W+1 bits.

## Timing
- Latency is one cycle for every control input: a change in the inputs sampled at edge k is visible on step, out and wrap after edge k.
- Throughput is one step per cycle with en held high.
- With en=1 and defaults, out cycles 0x0001, 0x0002, … 0x8000, 0x0001 with a 16-cycle period.
- wrap is high exactly one cycle per wrap event.
- rst asserted mid-sequence returns to step 0 on that edge without a wrap pulse.
- No combinational path from any input to any output.

## Structure
- A shared package holds:
  - the step index typedef for SEL_W=4;
  - the default T-state constants (T1..T6 indices);
  - SAP's LAST_STEP default of 5 (6 T-states).
- One natural sub-module is onehot_encode: a combinational SEL_W -> N_OUT one-hot with a default branch that yields all-zero for out-of-range input. It computes the next value of out from next-step. The registers live in the top module.

## Test plan
- Reset with defaults: rst=1 for 2 cycles -> step=0, out=0x0001, wrap=0, load_err=0; never X.
- Free run with defaults, en=1 for 17 cycles:
  - out walks 0x0001..0x8000 then back to 0x0001;
  - wrap is high only in the cycle after step 15 -> 0.
- LAST_STEP=5, en=1: step sequence 0,1,2,3,4,5,0; out=0x0020 then 0x0001 with wrap=1; repeat 3 periods.
- Early restart: at step 3 assert restart with en=1 -> next step=0, out=0x0001, wrap=1. load and restart asserted together with load_sel=7 -> step=7, wrap=0.
- Bad load: N_OUT=12, load_sel=13 -> step unchanged, load_err=1, which stays set across 20 cycles and clears only on rst.
- en low / rst mid-run:
  - en=0 for 5 cycles at step 9 -> step stays 9 and out stays 0x0200;
  - rst at step 9 -> step=0 and wrap=0 on the next edge.
